// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider state encoding and a
// magnitude helper used when capturing signed operands.
package alu_pkg;

    localparam int WIDTH      = 16;
    localparam int ITER_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // |x| when signed; the most negative value maps to its unsigned bit pattern.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/seq_divider16_if.sv
// Request/result bundle between the ALU sequencer (master) and the divider (slave).
interface seq_divider16_if;
    import alu_pkg::*;

    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overF;

    modport master (
        output start, sign, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overF
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overF
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and keep the trial difference when it does not borrow.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);
    localparam int N = WIDTH + 1;

    logic [N-1:0] rp;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   carry;
    logic [N-2:0] diff;

    // A restored remainder is always below the divisor, so only the shifted
    // trial value needs the extra bit.
    assign rp = {r, q_msb};
    assign g  = rp & ~{1'b0, dmag};
    assign p  = rp ^ ~{1'b0, dmag};

    // Carry-lookahead subtractor (a + ~b + 1): group carries every 4 bits hop
    // from group base to group base, bit carries fan out from their group base.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 1; i <= N; i++) begin
            int   base;
            logic acc;
            base = ((i % 4) == 0) ? (i - 4) : (4 * (i / 4));
            acc  = carry[base];
            for (int j = base; j < i; j++) begin
                acc = g[j] | (p[j] & acc);
            end
            carry[i] = acc;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_sum
            assign diff[gi] = p[gi] ^ carry[gi];
        end
    endgenerate

    // No borrow out of the WIDTH+1 bit subtraction means the trial is non-negative.
    assign q_bit  = carry[N];
    assign r_next = q_bit ? diff[WIDTH-1:0] : rp[WIDTH-1:0];

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed results
// recovered from magnitudes in a single fix-up cycle.
module seq_divider16 #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_divider16_if.slave  bus
);
    localparam int CW = alu_pkg::ITER_CNT_W;

    localparam logic [1:0] ST_IDLE = alu_pkg::IDLE;
    localparam logic [1:0] ST_ITER = alu_pkg::ITER;
    localparam logic [1:0] ST_FIX  = alu_pkg::FIX;
    localparam logic [1:0] ST_DONE = alu_pkg::DONE;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dmag_reg;
    logic             sign_reg;
    logic             dneg_reg;
    logic             vneg_reg;
    logic             ovf_pend_reg;

    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             dbz_reg;
    logic             overf_reg;

    logic [WIDTH-1:0] step_r;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .dmag   (dmag_reg),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            r_reg        <= '0;
            q_reg        <= '0;
            dmag_reg     <= '0;
            sign_reg     <= 1'b0;
            dneg_reg     <= 1'b0;
            vneg_reg     <= 1'b0;
            ovf_pend_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            dbz_reg      <= 1'b0;
            overf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        sign_reg     <= bus.sign;
                        dneg_reg     <= bus.sign & bus.dividend[WIDTH-1];
                        vneg_reg     <= bus.sign & bus.divisor[WIDTH-1];
                        ovf_pend_reg <= bus.sign && (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                        r_reg        <= '0;
                        q_reg        <= alu_pkg::mag(bus.dividend, bus.sign);
                        dmag_reg     <= alu_pkg::mag(bus.divisor, bus.sign);
                        cnt_reg      <= CW'(ITER - 1);
                        if (bus.divisor == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            quo_reg   <= '1;
                            rem_reg   <= bus.dividend;
                            dbz_reg   <= 1'b1;
                            overf_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_ITER;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_ITER: begin
                    r_reg   <= step_r;
                    q_reg   <= {q_reg[WIDTH-2:0], step_q};
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Truncating division: quotient sign is the XOR of operand
                    // signs, remainder follows the dividend.
                    quo_reg   <= (sign_reg && (dneg_reg ^ vneg_reg)) ? -q_reg : q_reg;
                    rem_reg   <= dneg_reg ? -r_reg : r_reg;
                    dbz_reg   <= 1'b0;
                    overf_reg <= ovf_pend_reg;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quo_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.overF       = overf_reg;

endmodule

// File: tb/tb_seq_divider16.sv
// Randomized and directed checks of seq_divider16 against an integer-arithmetic
// reference of truncating signed/unsigned division.
module tb_seq_divider16;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    seq_divider16_if bus ();

    seq_divider16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation for signed.
    task automatic ref_div(input logic s, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic dbz, output logic ovf);
        int sa, sb, qi, ri;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 16'h0000) begin
            q   = 16'hFFFF;
            r   = a;
            dbz = 1'b1;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            qi = sa / sb;
            ri = sa % sb;
            q  = qi[15:0];
            r  = ri[15:0];
            ovf = (a == 16'h8000) && (b == 16'hFFFF);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_quo"},  {16'd0, bus.quotient}, 32'd0);
        chk({tag, "_rem"},  {16'd0, bus.remainder}, 32'd0);
        chk({tag, "_flags"}, {30'd0, bus.div_by_zero, bus.overF}, 32'd0);
    endtask

    // inj > 0: pulse start with other operands after edge inj.
    // inj == -2: pulse start during the done cycle.
    // rst_at > 0: assert reset after edge rst_at and abandon the operation.
    task automatic run(input logic s, input logic [15:0] a, input logic [15:0] b,
                       input int inj, input int rst_at);
        logic [15:0] eq, er;
        logic        edbz, eovf;
        int          n;
        int          exp_lat;
        logic        got_done;
        logic        busy_seen;

        ref_div(s, a, b, eq, er, edbz, eovf);
        // Edges after the start edge until done is visible.
        exp_lat = (b == 16'h0000) ? 0 : 17;

        @(negedge clk);
        bus.start    = 1'b1;
        bus.sign     = s;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.sign     = 1'($urandom);
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
        busy_seen    = bus.busy;
        got_done     = bus.done;
        n            = 0;
        while (!got_done && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            bus.start = 1'b0;
            if (n == inj) begin
                bus.start    = 1'b1;
                bus.sign     = 1'b0;
                bus.dividend = 16'h0F0F;
                bus.divisor  = 16'h0003;
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_zero_outputs("async_reset");
                @(negedge clk);
                rst_n = 1'b1;
                $display("txn reset-abort s=%0d a=%h b=%h at edge %0d", s, a, b, n);
                return;
            end
            got_done = bus.done;
        end

        chk("latency", n, exp_lat);
        if (b != 16'h0000) chk("busy_after_start", {31'd0, busy_seen}, 32'd1);
        chk("quotient",    {16'd0, bus.quotient},  {16'd0, eq});
        chk("remainder",   {16'd0, bus.remainder}, {16'd0, er});
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, edbz});
        chk("overF",       {31'd0, bus.overF}, {31'd0, eovf});
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        $display("txn s=%0d a=%h b=%h -> q=%h r=%h dbz=%0d ovf=%0d lat=%0d (ref q=%h r=%h)",
                 s, a, b, bus.quotient, bus.remainder, bus.div_by_zero, bus.overF, n, eq, er);

        if (inj == -2) begin
            bus.start    = 1'b1;
            bus.dividend = 16'h0040;
            bus.divisor  = 16'h0000;
        end
        // done is a single pulse, nothing was queued, and results are held.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            chk("done_pulse", {31'd0, bus.done}, 32'd0);
            chk("no_restart", {31'd0, bus.busy}, 32'd0);
        end
        chk("held_quotient", {16'd0, bus.quotient}, {16'd0, eq});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rs;
        logic [15:0] ra, rb;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 16'd100,  16'd7,    0, 0);
        run(1'b1, 16'hFF9C, 16'h0007, 0, 0);
        run(1'b1, 16'h0064, 16'hFFF9, 0, 0);
        run(1'b0, 16'h1234, 16'h0000, 0, 0);
        run(1'b1, 16'h1234, 16'h0000, 0, 0);
        run(1'b1, 16'h8000, 16'hFFFF, 0, 0);
        run(1'b0, 16'h8000, 16'hFFFF, 0, 0);
        run(1'b0, 16'hFFFF, 16'h0001, 0, 0);
        run(1'b1, 16'h8000, 16'h0001, 0, 0);
        run(1'b0, 16'd100,  16'd7,    5, 0);
        run(1'b1, 16'hFF9C, 16'h0007, -2, 0);
        run(1'b0, 16'h5555, 16'h0003, 0, 8);
        run(1'b0, 16'hFFFF, 16'h0001, 0, 0);

        for (int t = 0; t < 60; t++) begin
            rs = 1'($urandom);
            ra = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(1, 15));
                2:       rb = 16'hFFFF;
                default: rb = 16'($urandom);
            endcase
            if (rb == 16'h0000 && $urandom_range(0, 1) == 1) rb = 16'h0001;
            run(rs, ra, rb, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
